// File: rtl/ex_muldiv_stage_pkg.sv
// ============================================================================
// core_pkg : shared types for the EX stage (forwarding select, M-op encoding,
//            mul/div FSM states) and the forwarding mux helper.
// Revision : 1.0
// ============================================================================
`default_nettype none

package core_pkg;

  localparam int DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    FW_NONE     = 2'b00,
    FW_MEM_ALU  = 2'b01,
    FW_MEM_DATA = 2'b10,
    FW_WB_DATA  = 2'b11
  } fw_sel_e;

  typedef enum logic [2:0] {
    MD_MUL    = 3'b000,
    MD_MULH   = 3'b001,
    MD_MULHSU = 3'b010,
    MD_MULHU  = 3'b011,
    MD_DIV    = 3'b100,
    MD_DIVU   = 3'b101,
    MD_REM    = 3'b110,
    MD_REMU   = 3'b111
  } md_op_e;

  typedef enum logic [1:0] {
    MD_IDLE = 2'b00,
    MD_BUSY = 2'b01,
    MD_DONE = 2'b10
  } md_state_e;

  function automatic logic [DATA_WIDTH-1:0] fw_mux(
    input fw_sel_e               sel,
    input logic [DATA_WIDTH-1:0] ex_val,
    input logic [DATA_WIDTH-1:0] mem_alu,
    input logic [DATA_WIDTH-1:0] mem_data,
    input logic [DATA_WIDTH-1:0] wb_data
  );
    case (sel)
      FW_MEM_ALU:  return mem_alu;
      FW_MEM_DATA: return mem_data;
      FW_WB_DATA:  return wb_data;
      default:     return ex_val;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/ex_muldiv_stage_if.sv
// ============================================================================
// ex_muldiv_stage_if : EX-stage operand/forwarding and M-op bus.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface ex_muldiv_stage_if;
  import core_pkg::*;

  logic [DATA_WIDTH-1:0] rs1_data_EX_i;
  logic [DATA_WIDTH-1:0] rs2_data_EX_i;
  fw_sel_e               forwardA;
  fw_sel_e               forwardB;
  logic [DATA_WIDTH-1:0] alu_result_MEM_i;
  logic [DATA_WIDTH-1:0] read_data_MEM_i;
  logic [DATA_WIDTH-1:0] wb_data_WB_i;
  logic                  md_valid_i;
  md_op_e                md_op_i;
  logic                  flush_i;
  logic [DATA_WIDTH-1:0] fwd_rs1_o;
  logic [DATA_WIDTH-1:0] fwd_rs2_o;
  logic [DATA_WIDTH-1:0] md_result_o;
  logic                  md_done_o;
  logic                  stall_EX_o;

  modport slave (
    input  rs1_data_EX_i, rs2_data_EX_i, forwardA, forwardB,
           alu_result_MEM_i, read_data_MEM_i, wb_data_WB_i,
           md_valid_i, md_op_i, flush_i,
    output fwd_rs1_o, fwd_rs2_o, md_result_o, md_done_o, stall_EX_o
  );

  modport master (
    output rs1_data_EX_i, rs2_data_EX_i, forwardA, forwardB,
           alu_result_MEM_i, read_data_MEM_i, wb_data_WB_i,
           md_valid_i, md_op_i, flush_i,
    input  fwd_rs1_o, fwd_rs2_o, md_result_o, md_done_o, stall_EX_o
  );

endinterface

`default_nettype wire

// File: rtl/ex_muldiv_stage_muldiv_core.sv
// ============================================================================
// muldiv_core : iterative RV32M multiply/divide FSM and datapath.
//               MULDIV_FAST_MUL_EN selects a single-cycle multiplier.
// Revision : 1.0
// ============================================================================
`default_nettype none

module muldiv_core
  import core_pkg::*;
#(
  parameter int DIV_ITERS = DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_valid,
  input  md_op_e                i_op,
  input  logic [DATA_WIDTH-1:0] i_op_a,
  input  logic [DATA_WIDTH-1:0] i_op_b,
  input  logic                  i_flush,
  output logic [DATA_WIDTH-1:0] o_result,
  output logic                  o_done,
  output logic                  o_stall
);

  localparam int c_W     = DATA_WIDTH;
  localparam int c_W2    = 2 * DATA_WIDTH;
  localparam int c_CNT_W = $clog2(DIV_ITERS + 1);
  localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(DIV_ITERS - 1);
`ifdef MULDIV_FAST_MUL_EN
  localparam bit c_FAST_MUL = 1'b1;
`else
  localparam bit c_FAST_MUL = 1'b0;
`endif

  md_state_e          r_state, w_next_state;
  md_op_e             r_op;
  logic               r_neg;
  logic [c_W-1:0]     r_hi, r_lo, r_b, r_result;
  logic [c_CNT_W-1:0] r_cnt;

  // Operand decode on the forwarded values, captured at start.
  logic           w_is_div, w_a_signed, w_b_signed, w_a_neg, w_b_neg, w_neg;
  logic           w_div_zero, w_ovf, w_fast, w_special;
  logic [c_W-1:0] w_a_mag, w_b_mag, w_special_res, w_fast_res;

  assign w_is_div   = i_op[2];
  assign w_a_signed = (i_op == MD_MUL) || (i_op == MD_MULH) || (i_op == MD_MULHSU) ||
                      (i_op == MD_DIV) || (i_op == MD_REM);
  assign w_b_signed = (i_op == MD_MUL) || (i_op == MD_MULH) ||
                      (i_op == MD_DIV) || (i_op == MD_REM);
  assign w_a_neg    = w_a_signed & i_op_a[c_W-1];
  assign w_b_neg    = w_b_signed & i_op_b[c_W-1];
  assign w_a_mag    = w_a_neg ? -i_op_a : i_op_a;
  assign w_b_mag    = w_b_neg ? -i_op_b : i_op_b;
  assign w_neg      = (i_op == MD_REM) ? w_a_neg : (w_a_neg ^ w_b_neg);

  assign w_div_zero = w_is_div && (i_op_b == '0);
  assign w_ovf      = ((i_op == MD_DIV) || (i_op == MD_REM)) &&
                      (i_op_a == {1'b1, {(c_W-1){1'b0}}}) && (i_op_b == '1);
  assign w_fast     = c_FAST_MUL && !w_is_div;
  assign w_special  = w_div_zero || w_ovf || w_fast;

  // i_op[1] separates REM/REMU from DIV/DIVU within the divide group.
  always_comb begin
    w_special_res = w_fast_res;
    if (w_div_zero)  w_special_res = i_op[1] ? i_op_a : '1;
    else if (w_ovf)  w_special_res = i_op[1] ? '0 : i_op_a;
  end

  generate
    if (c_FAST_MUL) begin : g_fast_mul
      logic signed [c_W2-1:0] w_full;
      assign w_full = c_W2'($signed({w_a_signed & i_op_a[c_W-1], i_op_a})) *
                      c_W2'($signed({w_b_signed & i_op_b[c_W-1], i_op_b}));
      assign w_fast_res = (i_op == MD_MUL) ? w_full[c_W-1:0] : w_full[c_W2-1:c_W];
    end else begin : g_iter_mul
      assign w_fast_res = '0;
    end
  endgenerate

  // One shift-add or restoring-subtract step on the magnitudes.
  logic [c_W:0]    w_mul_sum, w_div_sh;
  logic            w_div_ge;
  logic [c_W-1:0]  w_step_hi, w_step_lo, w_q_fix, w_r_fix, w_final;
  logic [c_W2-1:0] w_prod_fix;

  assign w_mul_sum = {1'b0, r_hi} + {1'b0, (r_lo[0] ? r_b : {c_W{1'b0}})};
  assign w_div_sh  = {r_hi, r_lo[c_W-1]};
  assign w_div_ge  = (w_div_sh >= {1'b0, r_b});

  always_comb begin
    if (r_op[2]) begin
      w_step_hi = w_div_ge ? (w_div_sh[c_W-1:0] - r_b) : w_div_sh[c_W-1:0];
      w_step_lo = {r_lo[c_W-2:0], w_div_ge};
    end else begin
      w_step_hi = w_mul_sum[c_W:1];
      w_step_lo = {w_mul_sum[0], r_lo[c_W-1:1]};
    end
  end

  assign w_prod_fix = r_neg ? -{w_step_hi, w_step_lo} : {w_step_hi, w_step_lo};
  assign w_q_fix    = r_neg ? -w_step_lo : w_step_lo;
  assign w_r_fix    = r_neg ? -w_step_hi : w_step_hi;

  always_comb begin
    case (r_op)
      MD_MUL:                          w_final = w_prod_fix[c_W-1:0];
      MD_MULH, MD_MULHSU, MD_MULHU:    w_final = w_prod_fix[c_W2-1:c_W];
      MD_DIV, MD_DIVU:                 w_final = w_q_fix;
      default:                         w_final = w_r_fix;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= MD_IDLE;
    else     r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      MD_IDLE: if (i_valid) w_next_state = w_special ? MD_DONE : MD_BUSY;
      MD_BUSY: if (r_cnt == c_LAST) w_next_state = MD_DONE;
      MD_DONE: w_next_state = MD_IDLE;
      default: w_next_state = MD_IDLE;
    endcase
    if (i_flush) w_next_state = MD_IDLE;
  end

  always_comb begin
    o_stall = 1'b0;
    o_done  = 1'b0;
    if (!i_flush) begin
      case (r_state)
        MD_IDLE: o_stall = i_valid;
        MD_BUSY: o_stall = 1'b1;
        MD_DONE: o_done  = 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_op     <= MD_MUL;
      r_neg    <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_b      <= '0;
      r_cnt    <= '0;
      r_result <= '0;
    end else if (i_flush) begin
      r_cnt <= '0;
    end else begin
      case (r_state)
        MD_IDLE: if (i_valid) begin
          r_op  <= i_op;
          r_neg <= w_neg;
          r_hi  <= '0;
          r_lo  <= w_a_mag;
          r_b   <= w_b_mag;
          r_cnt <= '0;
          if (w_special) r_result <= w_special_res;
        end
        MD_BUSY: begin
          r_hi  <= w_step_hi;
          r_lo  <= w_step_lo;
          r_cnt <= r_cnt + c_CNT_W'(1);
          if (r_cnt == c_LAST) r_result <= w_final;
        end
        default: ;
      endcase
    end
  end

  assign o_result = r_result;

endmodule

`default_nettype wire

// File: rtl/ex_muldiv_stage.sv
// ============================================================================
// ex_muldiv_stage : EX operand forwarding muxes plus RV32M mul/div unit.
//                   MULDIV_FAST_MUL_EN enables the single-cycle multiplier.
// Revision : 1.0
// ============================================================================
`default_nettype none

module ex_muldiv_stage
  import core_pkg::*;
#(
  parameter int DIV_ITERS = DATA_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  ex_muldiv_stage_if.slave md_bus
);

  assign md_bus.fwd_rs1_o = fw_mux(md_bus.forwardA, md_bus.rs1_data_EX_i,
                                   md_bus.alu_result_MEM_i, md_bus.read_data_MEM_i,
                                   md_bus.wb_data_WB_i);
  assign md_bus.fwd_rs2_o = fw_mux(md_bus.forwardB, md_bus.rs2_data_EX_i,
                                   md_bus.alu_result_MEM_i, md_bus.read_data_MEM_i,
                                   md_bus.wb_data_WB_i);

  muldiv_core #(
    .DIV_ITERS (DIV_ITERS)
  ) u_muldiv_core (
    .clk      (clk),
    .rst      (rst),
    .i_valid  (md_bus.md_valid_i),
    .i_op     (md_bus.md_op_i),
    .i_op_a   (md_bus.fwd_rs1_o),
    .i_op_b   (md_bus.fwd_rs2_o),
    .i_flush  (md_bus.flush_i),
    .o_result (md_bus.md_result_o),
    .o_done   (md_bus.md_done_o),
    .o_stall  (md_bus.stall_EX_o)
  );

endmodule

`default_nettype wire

// File: tb/tb_ex_muldiv_stage.sv
// ============================================================================
// tb_ex_muldiv_stage : vector table, random ops against an arithmetic model,
//                      and hand sequences for flush and mid-op reset.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_ex_muldiv_stage;
  import core_pkg::*;

`ifdef MULDIV_FAST_MUL_EN
  localparam int c_MUL_STALL = 1;
`else
  localparam int c_MUL_STALL = 33;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad = 0;
  logic [31:0] last_exp = '0;

  always #5 clk = ~clk;

  ex_muldiv_stage_if bus ();

  ex_muldiv_stage #(.DIV_ITERS(32)) dut (
    .clk    (clk),
    .rst    (rst),
    .md_bus (bus)
  );

  typedef struct {
    string       name;
    md_op_e      op;
    fw_sel_e     fa;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          stall;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] model(input md_op_e op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ua, ub;
    logic [63:0] t;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'b0, a});
    ub = longint'({32'b0, b});
    case (op)
      MD_MUL:    begin t = sa * sb; return t[31:0];  end
      MD_MULH:   begin t = sa * sb; return t[63:32]; end
      MD_MULHSU: begin t = sa * ub; return t[63:32]; end
      MD_MULHU:  begin t = ua * ub; return t[63:32]; end
      MD_DIV:    begin if (b == 0) return 32'hFFFF_FFFF; t = sa / sb; return t[31:0]; end
      MD_DIVU:   begin if (b == 0) return 32'hFFFF_FFFF; t = ua / ub; return t[31:0]; end
      MD_REM:    begin if (b == 0) return a; t = sa % sb; return t[31:0]; end
      default:   begin if (b == 0) return a; t = ua % ub; return t[31:0]; end
    endcase
  endfunction

  function automatic int model_stall(input md_op_e op, input logic [31:0] a, input logic [31:0] b);
    if (op inside {MD_MUL, MD_MULH, MD_MULHSU, MD_MULHU}) return c_MUL_STALL;
    if (b == 0) return 1;
    if ((op inside {MD_DIV, MD_REM}) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  function automatic logic [31:0] fw_model(input fw_sel_e s, input logic [31:0] ex,
                                           input logic [31:0] alu, input logic [31:0] mem,
                                           input logic [31:0] wb);
    if (s == FW_MEM_ALU)  return alu;
    if (s == FW_MEM_DATA) return mem;
    if (s == FW_WB_DATA)  return wb;
    return ex;
  endfunction

  task automatic scramble();
    bus.rs1_data_EX_i    = $urandom;
    bus.rs2_data_EX_i    = $urandom;
    bus.alu_result_MEM_i = $urandom;
    bus.read_data_MEM_i  = $urandom;
    bus.wb_data_WB_i     = $urandom;
  endtask

  // Starts an op at the current point (just after a falling edge) and runs to done.
  task automatic run_op(input string name, input md_op_e op, input fw_sel_e fa,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input int exp_stall);
    int stalls;
    scramble();
    bus.forwardA = fa;
    bus.forwardB = FW_NONE;
    bus.rs2_data_EX_i = b;
    case (fa)
      FW_MEM_ALU:  bus.alu_result_MEM_i = a;
      FW_MEM_DATA: bus.read_data_MEM_i  = a;
      FW_WB_DATA:  bus.wb_data_WB_i     = a;
      default:     bus.rs1_data_EX_i    = a;
    endcase
    bus.md_op_i    = op;
    bus.md_valid_i = 1'b1;
    #1;
    stalls = 0;
    while (bus.stall_EX_o === 1'b1 && stalls <= 100) begin
      stalls++;
      @(negedge clk);
      if (stalls == 1) scramble();
      #1;
    end
    chk({name, "_stall"}, stalls, exp_stall);
    chk({name, "_done"}, {31'b0, bus.md_done_o}, 32'd1);
    chk({name, "_result"}, bus.md_result_o, exp);
    last_exp = exp;
    bus.md_valid_i = 1'b0;
  endtask

  initial begin
    vecs[0] = '{"mul_neg",    MD_MUL,    FW_NONE,     32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, c_MUL_STALL};
    vecs[1] = '{"mulhu",      MD_MULHU,  FW_NONE,     32'd7,          32'hFFFF_FFFD, 32'h0000_0006, c_MUL_STALL};
    vecs[2] = '{"mulh_min",   MD_MULH,   FW_WB_DATA,  32'h8000_0000,  32'h8000_0000, 32'h4000_0000, c_MUL_STALL};
    vecs[3] = '{"mulhsu",     MD_MULHSU, FW_NONE,     32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, c_MUL_STALL};
    vecs[4] = '{"div_ovf",    MD_DIV,    FW_NONE,     32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1};
    vecs[5] = '{"rem_ovf",    MD_REM,    FW_NONE,     32'h8000_0000,  32'hFFFF_FFFF, 32'h0000_0000, 1};
    vecs[6] = '{"divu_zero",  MD_DIVU,   FW_MEM_DATA, 32'd100,        32'd0,         32'hFFFF_FFFF, 1};
    vecs[7] = '{"remu_zero",  MD_REMU,   FW_NONE,     32'd100,        32'd0,         32'd100,       1};
    vecs[8] = '{"div_m7_2",   MD_DIV,    FW_MEM_ALU,  32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 33};
    vecs[9] = '{"rem_m7_2",   MD_REM,    FW_MEM_ALU,  32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 33};

    bus.forwardA = FW_NONE;
    bus.forwardB = FW_NONE;
    bus.md_valid_i = 1'b0;
    bus.md_op_i = MD_MUL;
    bus.flush_i = 1'b0;
    scramble();
    repeat (2) @(negedge clk);
    chk("reset_stall", {31'b0, bus.stall_EX_o}, 32'd0);
    chk("reset_done", {31'b0, bus.md_done_o}, 32'd0);
    chk("reset_result", bus.md_result_o, 32'd0);
    rst = 1'b0;

    // Forwarding muxes.
    @(negedge clk);
    bus.forwardA = FW_MEM_DATA;
    bus.read_data_MEM_i = 32'h1234;
    bus.forwardB = FW_WB_DATA;
    bus.wb_data_WB_i = 32'hBEEF;
    #1;
    chk("fwd_rs1_mem", bus.fwd_rs1_o, 32'h1234);
    chk("fwd_rs2_wb", bus.fwd_rs2_o, 32'hBEEF);
    for (int i = 0; i < 8; i++) begin
      scramble();
      bus.forwardA = fw_sel_e'(2'(i));
      bus.forwardB = fw_sel_e'(2'(7 - i));
      #1;
      chk("fwd_rs1", bus.fwd_rs1_o, fw_model(bus.forwardA, bus.rs1_data_EX_i,
          bus.alu_result_MEM_i, bus.read_data_MEM_i, bus.wb_data_WB_i));
      chk("fwd_rs2", bus.fwd_rs2_o, fw_model(bus.forwardB, bus.rs2_data_EX_i,
          bus.alu_result_MEM_i, bus.read_data_MEM_i, bus.wb_data_WB_i));
    end

    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      run_op(vecs[i].name, vecs[i].op, vecs[i].fa, vecs[i].a, vecs[i].b,
             vecs[i].exp, vecs[i].stall);
    end

    // Flush during a divide: no done, result held, then a fresh MUL.
    begin
      int   step;
      logic seen_done;
      @(negedge clk);
      scramble();
      bus.forwardA = FW_NONE;
      bus.forwardB = FW_NONE;
      bus.rs1_data_EX_i = 32'd1000;
      bus.rs2_data_EX_i = 32'd7;
      bus.md_op_i = MD_DIVU;
      bus.md_valid_i = 1'b1;
      seen_done = 1'b0;
      for (step = 0; step < 11; step++) begin
        @(negedge clk);
        #1;
        seen_done |= bus.md_done_o;
      end
      bus.flush_i = 1'b1;
      bus.md_valid_i = 1'b0;
      #1;
      chk("flush_stall", {31'b0, bus.stall_EX_o}, 32'd0);
      chk("flush_done", {31'b0, bus.md_done_o}, 32'd0);
      @(negedge clk);
      bus.flush_i = 1'b0;
      #1;
      seen_done |= bus.md_done_o;
      chk("flush_no_done", {31'b0, seen_done}, 32'd0);
      chk("flush_result_held", bus.md_result_o, last_exp);
      run_op("mul_after_flush", MD_MUL, FW_NONE, 32'd3, 32'd4, 32'd12, c_MUL_STALL);
    end

    // Asynchronous reset in the middle of an iterative op.
    begin
      logic seen_done;
      @(negedge clk);
      bus.rs1_data_EX_i = 32'd1000;
      bus.rs2_data_EX_i = 32'd3;
      bus.md_op_i = MD_DIVU;
      bus.md_valid_i = 1'b1;
      repeat (5) @(negedge clk);
      bus.md_valid_i = 1'b0;
      #2 rst = 1'b1;
      #1;
      chk("rst_mid_stall", {31'b0, bus.stall_EX_o}, 32'd0);
      chk("rst_mid_result", bus.md_result_o, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      seen_done = 1'b0;
      for (int i = 0; i < 40; i++) begin
        @(negedge clk);
        seen_done |= bus.md_done_o;
      end
      chk("rst_mid_no_done", {31'b0, seen_done}, 32'd0);
    end

    // Random ops against the arithmetic model, with latched-operand scrambling.
    for (int i = 0; i < 40; i++) begin
      md_op_e      op;
      fw_sel_e     fa;
      logic [31:0] a, b;
      int          r;
      op = md_op_e'(3'($urandom_range(0, 7)));
      fa = fw_sel_e'(2'($urandom_range(0, 3)));
      a  = $urandom;
      b  = $urandom;
      r  = $urandom_range(0, 9);
      if (r == 0) b = 32'd0;
      if (r == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
      if (r == 2) b = $urandom_range(1, 15);
      @(negedge clk);
      run_op("rnd", op, fa, a, b, model(op, a, b), model_stall(op, a, b));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
